// File: rtl/button_events_pkg.sv
// Shared types and default thresholds for the button gesture classifier.
// Imported by the classifier itself and by any top level or bench that instantiates it.
package button_events_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        LONG_HELD = 3'd4
    } state_t;

    localparam int LONG_CYCLES_DEFAULT       = 1024 * 1024 * 25;
    localparam int DOUBLE_GAP_CYCLES_DEFAULT = 1024 * 1024 * 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_events_if.sv
// Button level in, gesture event pulses out.
// The master drives the level; the slave (the classifier) drives the events.
interface button_events_if;

    logic i_button;
    logic o_click;
    logic o_double;
    logic o_long;
    logic o_busy;

    modport master (
        output i_button,
        input  o_click,
        input  o_double,
        input  o_long,
        input  o_busy
    );

    modport slave (
        input  i_button,
        output o_click,
        output o_double,
        output o_long,
        output o_busy
    );

endinterface

// File: rtl/button_events.sv
// Turns a debounced button level into one-cycle click / double-click / long-press pulses.
// One shared counter times both the press length and the inter-press gap.
`ifndef BUTTON_EVENTS_SV
`define BUTTON_EVENTS_SV

module button_events
    import button_events_pkg::*;
#(
    parameter int LONG_CYCLES       = LONG_CYCLES_DEFAULT,
    parameter int DOUBLE_GAP_CYCLES = DOUBLE_GAP_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            i_reset,
    button_events_if.slave  bus
);

    localparam int CNT_WIDTH = $clog2(max_int(LONG_CYCLES, DOUBLE_GAP_CYCLES)) + 1;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE       = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] LONG_LAST     = CNT_WIDTH'(LONG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST      = CNT_WIDTH'(DOUBLE_GAP_CYCLES - 1);

    state_t                state_reg, state_next;
    logic [CNT_WIDTH-1:0]  cnt_reg,   cnt_next;
    logic                  click_reg,  click_next;
    logic                  double_reg, double_next;
    logic                  long_reg,   long_next;
    logic                  busy_reg;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            click_reg  <= 1'b0;
            double_reg <= 1'b0;
            long_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            click_reg  <= click_next;
            double_reg <= double_next;
            long_reg   <= long_next;
            busy_reg   <= (state_next != IDLE);
        end
    end

    // Button edges are checked before timeouts so a coincident press/release always wins.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        click_next  = 1'b0;
        double_next = 1'b0;
        long_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.i_button) begin
                    state_next = PRESS1;
                    cnt_next   = CNT_ONE;
                end
            end
            PRESS1: begin
                if (!bus.i_button) begin
                    state_next = WAIT2;
                    cnt_next   = CNT_ONE;
                end else if (cnt_reg == LONG_LAST) begin
                    state_next = LONG_HELD;
                    long_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            WAIT2: begin
                if (bus.i_button) begin
                    state_next = PRESS2;
                end else if (cnt_reg == GAP_LAST) begin
                    state_next = IDLE;
                    click_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            PRESS2: begin
                if (!bus.i_button) begin
                    state_next  = IDLE;
                    double_next = 1'b1;
                end
            end
            LONG_HELD: begin
                if (!bus.i_button) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign bus.o_click  = click_reg;
    assign bus.o_double = double_reg;
    assign bus.o_long   = long_reg;
    assign bus.o_busy   = busy_reg;

endmodule

`endif

// File: tb/tb_button_events.sv
// Directed bench for button_events with LONG_CYCLES=8, DOUBLE_GAP_CYCLES=4.
// Each step drives reset/button for one edge, then checks {click, double, long, busy}.
module tb_button_events;

    logic clk;
    logic i_reset;

    button_events_if bus ();

    button_events #(
        .LONG_CYCLES       (8),
        .DOUBLE_GAP_CYCLES (4)
    ) dut (
        .clk     (clk),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       btn;
        logic [3:0] exp;   // {click, double, long, busy}
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;
    int   step_no;

    task automatic add(input int n, input logic r, input logic b, input logic [3:0] e);
        vec_t v;
        v.rst = r;
        v.btn = b;
        v.exp = e;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic b, input logic [3:0] e, input string name);
        logic [3:0] got;
        i_reset      = r;
        bus.i_button = b;
        @(posedge clk);
        #1;
        got = {bus.o_click, bus.o_double, bus.o_long, bus.o_busy};
        step_no++;
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s step %0d rst=%0b btn=%0b got=%b expected=%b", name, step_no, r, b, got, e);
        end else begin
            $display("ok   %s step %0d rst=%0b btn=%0b out=%b", name, step_no, r, b, got);
        end
        checks++;
        if ($countones(got[3:1]) > 1) begin
            errors++;
            $display("FAIL onehot step %0d got=%b expected at most one event", step_no, got);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        step_no      = 0;
        i_reset      = 1'b1;
        bus.i_button = 1'b0;

        // Reset state
        add(2, 1, 0, 4'b0000);
        // Short press of 3, then the gap expires into a click
        add(3, 0, 1, 4'b0001);
        add(3, 0, 0, 4'b0001);
        add(1, 0, 0, 4'b1000);
        add(2, 0, 0, 4'b0000);
        // Held 20 cycles: long on the 8th sample, silent release
        add(7, 0, 1, 4'b0001);
        add(1, 0, 1, 4'b0011);
        add(12, 0, 1, 4'b0001);
        add(2, 0, 0, 4'b0000);
        // High 2, low 2, high 2, low: double
        add(2, 0, 1, 4'b0001);
        add(2, 0, 0, 4'b0001);
        add(2, 0, 1, 4'b0001);
        add(1, 0, 0, 4'b0100);
        add(1, 0, 0, 4'b0000);
        // High 2, low exactly 4 (click), high 2 starts a fresh gesture
        add(2, 0, 1, 4'b0001);
        add(3, 0, 0, 4'b0001);
        add(1, 0, 0, 4'b1000);
        add(2, 0, 1, 4'b0001);
        add(3, 0, 0, 4'b0001);
        add(1, 0, 0, 4'b1000);
        add(1, 0, 0, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].btn, vecs[i].exp, "table");
        end

        // Release on what would be the 8th high sample: no long, click after 4 lows
        repeat (7) step(0, 1, 4'b0001, "release_wins");
        repeat (3) step(0, 0, 4'b0001, "release_wins");
        step(0, 0, 4'b1000, "release_wins");
        step(0, 0, 4'b0000, "release_wins");

        // Press on the 4th low sample (gap would expire): press wins, no click
        step(0, 1, 4'b0001, "press_wins");
        repeat (3) step(0, 0, 4'b0001, "press_wins");
        step(0, 1, 4'b0001, "press_wins");
        repeat (5) step(0, 1, 4'b0001, "press_wins");
        step(0, 0, 4'b0100, "press_wins");
        step(0, 0, 4'b0000, "press_wins");

        // Reset mid-press with the button held: long needs 8 fresh samples
        repeat (5) step(0, 1, 4'b0001, "reset_mid");
        step(1, 1, 4'b0000, "reset_mid");
        repeat (7) step(0, 1, 4'b0001, "reset_mid");
        step(0, 1, 4'b0011, "reset_mid");
        step(0, 1, 4'b0001, "reset_mid");
        step(0, 0, 4'b0000, "reset_mid");
        step(0, 0, 4'b0000, "reset_mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_events.md
# button_events

Classifies a debounced, active-high button level into single-cycle click, double-click and long-press event pulses. It sits between a button debouncer and event consumers such as the click-driven state mux and the reset-combine logic. It turns the clean level stream into discrete gesture events, so downstream blocks never time presses themselves.

## Interface
- `LONG_CYCLES`, default 1024*1024*25: consecutive high samples that make a long press; minimum 2.
- `DOUBLE_GAP_CYCLES`, default 1024*1024*10: consecutive low samples after a first release that close the double-click window; minimum 2.
- `CNT_WIDTH`, localparam, not overridable: `$clog2(max(LONG_CYCLES, DOUBLE_GAP_CYCLES)) + 1`.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_button`  in  1  debounced button level, 1 = pressed; synchronous to `clk`.
- `o_click`  out  1  one-cycle pulse for a single short press.
- `o_double`  out  1  one-cycle pulse for two short presses inside the gap window.
- `o_long`  out  1  one-cycle pulse when a first press reaches `LONG_CYCLES`.
- `o_busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- The FSM has five states, one counter `cnt` and registered outputs.
- **IDLE**
  - `i_button`=1 → PRESS1, with `cnt`=1.
- **PRESS1**
  - `i_button`=0 → WAIT2, with `cnt`=1.
  - Otherwise, when `cnt`==`LONG_CYCLES`-1 → pulse `o_long` and go to LONG_HELD.
  - Otherwise `cnt`++.
- **WAIT2**
  - `i_button`=1 → PRESS2.
  - Otherwise, when `cnt`==`DOUBLE_GAP_CYCLES`-1 → pulse `o_click` and go to IDLE.
  - Otherwise `cnt`++.
- **PRESS2**
  - `i_button`=0 → pulse `o_double` and go to IDLE.
  - No timeout: a held second press stays in PRESS2 and still reports `o_double` on release.
- **LONG_HELD**
  - `i_button`=0 → IDLE, with no event.
- A release in the same cycle that the long threshold would be hit: release wins, no `o_long`.
- A press in the same cycle that the gap would expire: press wins, go to PRESS2, no `o_click`.
- At most one of `o_click`/`o_double`/`o_long` is high in any cycle.
- Every output pulse lasts exactly one cycle.
- Reset forces IDLE, `cnt`=0 and all outputs 0, and discards any in-flight gesture.
- A button still held when reset deasserts is treated as a fresh press starting at the first post-reset sample.

## Timing
- Reset values: `o_click`=`o_double`=`o_long`=`o_busy`=0.
- `o_long` is high in the cycle after the edge at which `i_button` has been sampled high on `LONG_CYCLES` consecutive edges.
- `o_click` is high in the cycle after the edge at which `i_button` has been sampled low on `DOUBLE_GAP_CYCLES` consecutive edges following the first release.
- `o_double` is high in the cycle after the first edge that samples `i_button`=0 in PRESS2.
- `o_busy` is registered: it rises in the cycle after the first high sample and falls in the same cycle as the final event pulse, or the LONG_HELD exit.
- Gesture latency:
  - Click: release + `DOUBLE_GAP_CYCLES`.
  - Double: 1 cycle after the second release.
- `cnt` never exceeds `max(LONG_CYCLES, DOUBLE_GAP_CYCLES)`, so no wrap is possible.

## Structure
- `button_events_pkg` holds:
  - the `state_t` enum (IDLE, PRESS1, WAIT2, PRESS2, LONG_HELD);
  - the default thresholds as named constants, for reuse by top levels and benches.
- No sub-module: the single counter and the FSM live in one module.
- The module is wrapped in an include guard, consistent with the other debug-path blocks.

## Test plan
All scenarios use `LONG_CYCLES`=8 and `DOUBLE_GAP_CYCLES`=4.
- Press for 3 cycles, then release and hold low → exactly one `o_click` on the cycle after the 4th low sample; `o_double` and `o_long` stay 0 throughout.
- Hold high for 20 cycles → `o_long` on the cycle after the 8th high sample; no event on release; `o_busy` falls after release.
- High 2, low 2, high 2, low → `o_double` on the cycle after the second low sample; no `o_click`.
- High 2, then low for exactly 4, then high 2 → `o_click` after the 4th low sample, then a new sequence in PRESS1; no `o_double`.
- Release coincident with the 8th high sample, so only 7 high samples are seen → no `o_long`; `o_click` follows 4 lows later.
- Hold high, then assert `i_reset` for 1 cycle at the 6th sample with the button kept high → no `o_long` until 8 fresh post-reset high samples; all outputs are 0 during and immediately after reset.
